// File: rtl/mux_2to1_pkg.sv
// -----------------------------------------------------------------------------
// mux_2to1_pkg
// Shared constants for the datapath two-input selector.
//   DATA_W   : CPU-wide data word width, default width of mux_2to1.
//   SEL_DIN1 : select code that picks din1.
//   SEL_DIN2 : select code that picks din2.
// Datapath control decoders use the named select codes rather than raw bits.
// -----------------------------------------------------------------------------
package mux_2to1_pkg;

    localparam int   DATA_W   = 32'd32;
    localparam logic SEL_DIN1 = 1'b0;
    localparam logic SEL_DIN2 = 1'b1;

endpackage : mux_2to1_pkg

// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
// Two-input datapath selector with an optional output register.
//
// Parameters
//   WIDTH        : data width of din1, din2 and muxout (>= 1).
//   REGISTER_OUT : 1 = registered output, one-cycle latency;
//                  0 = purely combinational, clk/reset unused.
//
// Ports
//   clk    : in,  1 bit   rising-edge clock.
//   reset  : in,  1 bit   synchronous active-high reset (clears muxout).
//   sel    : in,  1 bit   SEL_DIN1 picks din1, SEL_DIN2 picks din2.
//   din1   : in,  WIDTH   data input 0.
//   din2   : in,  WIDTH   data input 1.
//   muxout : out, WIDTH   selected data, passed through unmodified.
// -----------------------------------------------------------------------------
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH        = DATA_W,
    parameter int REGISTER_OUT = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic [WIDTH-1:0] muxout
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 32'sd1) begin : g_bad_width
        $error("mux_2to1: WIDTH must be >= 1");
    end
    if ((REGISTER_OUT != 32'sd0) && (REGISTER_OUT != 32'sd1)) begin : g_bad_regout
        $error("mux_2to1: REGISTER_OUT must be 0 or 1");
    end

    // Selection shared by both builds. The conditional operator gives the
    // desired simulation behaviour for an unknown sel: bits where din1 and
    // din2 agree pass through, differing bits go X. Synthesis maps it to a
    // plain per-bit 2:1 mux.
    logic [WIDTH-1:0] sel_data_s;
    assign sel_data_s = (sel == SEL_DIN2) ? din2 : din1;

    if (REGISTER_OUT == 32'sd1) begin : g_reg
        logic [WIDTH-1:0] muxout_r;

        // Output register: reset has priority over data on the same edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                muxout_r <= '0;
            end else begin
                muxout_r <= sel_data_s;
            end
        end

        assign muxout = muxout_r;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic unused_s;
        assign unused_s = &{1'b0, clk, reset};

        assign muxout = sel_data_s;
    end

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1
// Self-checking bench for mux_2to1. A registered instance is driven cycle by
// cycle; each drive pushes the expected output into a scoreboard queue which
// is popped and compared one edge later. A second, combinational instance is
// checked with its clock held low.
// -----------------------------------------------------------------------------
module tb_mux_2to1;

    import mux_2to1_pkg::*;

    localparam int W = DATA_W;

    // Registered instance signals
    logic         clk;
    logic         reset;
    logic         sel;
    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic [W-1:0] muxout;

    // Combinational instance signals
    logic         c_clk;
    logic         c_reset;
    logic         c_sel;
    logic [W-1:0] c_din1;
    logic [W-1:0] c_din2;
    logic [W-1:0] c_muxout;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_q[$];

    mux_2to1 #(.WIDTH(W), .REGISTER_OUT(1)) u_dut_reg (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .din1   (din1),
        .din2   (din2),
        .muxout (muxout)
    );

    mux_2to1 #(.WIDTH(W), .REGISTER_OUT(0)) u_dut_comb (
        .clk    (c_clk),
        .reset  (c_reset),
        .sel    (c_sel),
        .din1   (c_din1),
        .din2   (c_din2),
        .muxout (c_muxout)
    );

    // Free-running clock for the registered instance.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference behaviour of the registered build for one edge.
    function automatic logic [W-1:0] model(input logic r, input logic s,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (r) return '0;
        return s ? b : a;
    endfunction

    // Drive one cycle of stimulus, push its expectation, then compare after the edge.
    task automatic cycle(input string tag, input logic r, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp;
        reset = r;
        sel   = s;
        din1  = a;
        din2  = b;
        exp_q.push_back(model(r, s, a, b));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check_val(tag, muxout, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        sel      = SEL_DIN1;
        din1     = 32'd0;
        din2     = 32'd0;
        c_clk    = 1'b0;
        c_reset  = 1'b0;
        c_sel    = SEL_DIN1;
        c_din1   = 32'd0;
        c_din2   = 32'd0;
        #2;

        // Reset held for two edges
        cycle("reset0", 1'b1, 1'b0, 32'd21, 32'd3);
        cycle("reset1", 1'b1, 1'b0, 32'd21, 32'd3);

        // Basic select
        cycle("sel_din1", 1'b0, 1'b0, 32'd21, 32'd3);
        cycle("sel_din2", 1'b0, 1'b1, 32'd21, 32'd3);

        // Per-cycle switching
        for (int i = 0; i < 8; i++) begin
            cycle("toggle", 1'b0, i[0], 32'hFFFF_FFFF, 32'h0000_0000);
        end

        // Reset wins over data on the same edge, nothing survives it
        cycle("rst_prio", 1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
        cycle("rst_release", 1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);

        // Inter-edge glitch on din1 must not reach the output
        reset = 1'b0;
        sel   = 1'b0;
        din1  = 32'd5;
        din2  = 32'd9;
        #2 din1 = 32'd7;
        #2 check_val("hold_between_edges", muxout, 32'hDEAD_BEEF);
        #2 din1 = 32'd5;
        exp_q.push_back(32'd5);
        @(posedge clk);
        #1;
        check_val("glitch", muxout, exp_q.pop_front());
        cycle("glitch_steady", 1'b0, 1'b0, 32'd5, 32'd9);

        // Random traffic including occasional reset
        for (int i = 0; i < 16; i++) begin
            cycle("random", ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  $urandom, $urandom);
        end

        // Combinational build, clock held low
        c_reset = 1'b1;
        c_sel   = SEL_DIN1;
        c_din1  = 32'd21;
        c_din2  = 32'd3;
        #1 check_val("comb_din1", c_muxout, 32'd21);
        c_sel = SEL_DIN2;
        #1 check_val("comb_din2", c_muxout, 32'd3);
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = ~a;
            c_sel  = i[0];
            c_din1 = a;
            c_din2 = b;
            #1 check_val("comb_random", c_muxout, i[0] ? b : a);
        end

        if (exp_q.size() != 0) begin
            check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_2to1
